// File: rtl/sign_load_deframer_if.sv
// Host load stream and forwarded-word slice of the sign-mode deframer.
// Host side:       valid_i (word valid), ready_i (deframer can accept), data_i (word).
// Downstream side: word_o/fld_o/idx_o/last_o (tagged word), wvalid_o (slice full),
//                  wready_i (downstream takes the word).
// slave  = deframer view, master = host/consumer view.
interface sign_load_deframer_if #(
  parameter int unsigned W     = 64,
  parameter int unsigned IDX_W = 9
);
  logic             valid_i;
  logic             ready_i;
  logic [W-1:0]     data_i;
  logic [W-1:0]     word_o;
  logic [2:0]       fld_o;
  logic [IDX_W-1:0] idx_o;
  logic             last_o;
  logic             wvalid_o;
  logic             wready_i;

  modport slave (
    input  valid_i, data_i, wready_i,
    output ready_i, word_o, fld_o, idx_o, last_o, wvalid_o
  );

  modport master (
    output valid_i, data_i, wready_i,
    input  ready_i, word_o, fld_o, idx_o, last_o, wvalid_o
  );
endinterface

// File: rtl/sign_load_deframer.sv
// Sign-mode input deframer: walks the host word stream through the fields
// rho, mlen, tr, msg, k, s1, s2, t0 and forwards every accepted word through a
// one-entry slice tagged with its field code and index within the field.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   start         one-cycle pulse arming a frame (ignored while busy)
//   sec_lvl       3'b010 / 3'b011 / 3'b101, sampled on start
//   bus           host stream + output slice (sign_load_deframer_if.slave)
//   mlen_o        low 32 bits of the mlen word
//   busy_o        frame in progress
//   done_o        pulse when the last t0 word is handed off
//   err_o         sticky, start seen with an illegal sec_lvl
module sign_load_deframer #(
  parameter int unsigned W     = 64,
  parameter int unsigned IDX_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           sec_lvl,
  sign_load_deframer_if.slave  bus,
  output logic [31:0]          mlen_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned CW = IDX_W + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RHO, S_MLEN, S_TR, S_MSG, S_K, S_S1, S_S2, S_T0
  } state_e;

  state_e           state_q;
  logic [1:0]       lvl_q;      // 0: L2, 1: L3, 2: L5
  logic [IDX_W-1:0] ctr_q;
  logic [W-1:0]     word_q;
  logic [2:0]       fld_q;
  logic [IDX_W-1:0] idx_q;
  logic             last_q;
  logic             wvalid_q;
  logic [31:0]      mlen_q;
  logic             busy_q;
  logic             err_q;

  logic             ready_c;
  logic             accept_c;
  logic             lvl_ok_c;
  logic [1:0]       lvl_c;
  logic [CW-1:0]    cnt_c;
  logic [2:0]       fld_c;
  logic [34:0]      msg_bits_c;
  logic [34:0]      mlen_bits_c;
  logic             last_c;

  // Security level decode at start.
  always_comb begin
    lvl_ok_c = 1'b1;
    lvl_c    = 2'd0;
    case (sec_lvl)
      3'b010:  lvl_c = 2'd0;
      3'b011:  lvl_c = 2'd1;
      3'b101:  lvl_c = 2'd2;
      default: lvl_ok_c = 1'b0;
    endcase
  end

  // Word count of the current fixed-length field and last-word decision.
  always_comb begin
    cnt_c = CW'(4);
    case (state_q)
      S_MLEN: cnt_c = CW'(1);
      S_S1:   cnt_c = (lvl_q == 2'd0) ? CW'(48)  : (lvl_q == 2'd1) ? CW'(80)  : CW'(84);
      S_S2:   cnt_c = (lvl_q == 2'd0) ? CW'(48)  : CW'(96);
      S_T0:   cnt_c = (lvl_q == 2'd0) ? CW'(208) : (lvl_q == 2'd1) ? CW'(312) : CW'(416);
      default: cnt_c = CW'(4);
    endcase
    // msg ends once the words so far cover mlen bytes; mlen=0 still yields one word.
    msg_bits_c  = (35'(ctr_q) + 35'd1) * 35'(W);
    mlen_bits_c = {mlen_q, 3'b000};
    if (state_q == S_MSG) begin
      last_c = (msg_bits_c >= mlen_bits_c);
    end else begin
      last_c = (({1'b0, ctr_q} + CW'(1)) == cnt_c);
    end
    fld_c = 3'(4'(state_q) - 4'd1);
  end

  // Accept whenever the slice is empty or being drained this cycle.
  assign ready_c  = busy_q && (!wvalid_q || bus.wready_i);
  assign accept_c = bus.valid_i && ready_c;

  // Frame state, index counter and output slice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      lvl_q    <= 2'd0;
      ctr_q    <= '0;
      word_q   <= '0;
      fld_q    <= 3'd0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      wvalid_q <= 1'b0;
      mlen_q   <= 32'd0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept_c) begin
        word_q   <= bus.data_i;
        fld_q    <= fld_c;
        idx_q    <= ctr_q;
        last_q   <= last_c;
        wvalid_q <= 1'b1;
      end else if (bus.wready_i) begin
        wvalid_q <= 1'b0;
      end

      if (state_q == S_IDLE) begin
        if (start) begin
          if (lvl_ok_c) begin
            state_q <= S_RHO;
            busy_q  <= 1'b1;
            lvl_q   <= lvl_c;
            ctr_q   <= '0;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (accept_c) begin
        if (state_q == S_MLEN) begin
          mlen_q <= bus.data_i[31:0];
        end
        if (last_c) begin
          ctr_q <= '0;
          if (state_q == S_T0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= state_e'(4'(state_q) + 4'd1);
          end
        end else begin
          ctr_q <= ctr_q + IDX_W'(1);
        end
      end
    end
  end

  assign bus.ready_i  = ready_c;
  assign bus.word_o   = word_q;
  assign bus.fld_o    = fld_q;
  assign bus.idx_o    = idx_q;
  assign bus.last_o   = last_q;
  assign bus.wvalid_o = wvalid_q;
  assign mlen_o       = mlen_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  // Marks the hand-off of the final t0 word itself.
  assign done_o       = wvalid_q && bus.wready_i && (fld_q == 3'd7) && last_q;

endmodule
